// File: rtl/deserialize_shifter.sv
`default_nettype none
// ============================================================================
// Module   : deserialize_shifter
// Brief    : 8N1 serial receiver with mid-bit sampling and a valid/ack output.
// Revision : 1.0 - initial release
// ============================================================================
module deserialize_shifter #(
    parameter int SRC_CLOCK = 0,
    parameter int BAUDS     = 0
) (
    input  logic       ser_ck,
    input  logic       rst,
    input  logic       serin,
    input  logic       rx_ack,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy,
    output logic       frame_err,
    output logic       overrun
);

    // Guarded so an instance with unset parameters still elaborates.
    localparam int c_BAUD_DIV       = (BAUDS > 0) ? BAUDS : 1;
    localparam int c_RATIO_RAW      = SRC_CLOCK / c_BAUD_DIV;
    localparam int c_RATIO          = (c_RATIO_RAW >= 4) ? c_RATIO_RAW : 4;
    localparam int c_TICKS_PER_BAUD = c_RATIO - 1;
    localparam int c_HALF_BAUD      = c_TICKS_PER_BAUD / 2;
    localparam int c_CNT_W          = $clog2(c_TICKS_PER_BAUD + 1) + 1;

    localparam logic [c_CNT_W-1:0] c_TICKS_CNT = c_CNT_W'(c_TICKS_PER_BAUD);
    localparam logic [c_CNT_W-1:0] c_HALF_CNT  = c_CNT_W'(c_HALF_BAUD);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_START = 3'd1;
    localparam logic [2:0] c_ST_DATA  = 3'd2;
    localparam logic [2:0] c_ST_STOP  = 3'd3;
    localparam logic [2:0] c_ST_BREAK = 3'd4;

    logic [1:0]         r_sync;
    logic [2:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [2:0]         r_bit_idx;
    logic [7:0]         r_shift;
    logic [7:0]         r_rx_data;
    logic               r_rx_valid;
    logic               r_busy;
    logic               r_frame_err;
    logic               r_overrun;

    logic w_rxs;
    logic w_at_tick;
    logic w_at_half;

    assign w_rxs     = r_sync[1];
    assign w_at_tick = (r_cnt == c_TICKS_CNT);
    assign w_at_half = (r_cnt == c_HALF_CNT);

    always_ff @(posedge ser_ck or posedge rst) begin
        if (rst) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], serin};
        end
    end

    always_ff @(posedge ser_ck or posedge rst) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= 3'd0;
            r_shift     <= 8'd0;
            r_rx_data   <= 8'd0;
            r_rx_valid  <= 1'b0;
            r_busy      <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
            if (rx_ack) begin
                r_rx_valid <= 1'b0;
            end

            case (r_state)
                c_ST_IDLE: begin
                    r_busy <= 1'b0;
                    r_cnt  <= '0;
                    if (!w_rxs) begin
                        r_state <= c_ST_START;
                        r_busy  <= 1'b1;
                    end
                end
                c_ST_START: begin
                    if (w_at_half) begin
                        r_cnt <= '0;
                        if (!w_rxs) begin
                            r_state   <= c_ST_DATA;
                            r_bit_idx <= 3'd0;
                        end else begin
                            // Start bit vanished before mid-bit: treat as a glitch.
                            r_state <= c_ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                c_ST_DATA: begin
                    if (w_at_tick) begin
                        r_cnt              <= '0;
                        r_shift[r_bit_idx] <= w_rxs;
                        r_bit_idx          <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= c_ST_STOP;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                c_ST_STOP: begin
                    if (w_at_tick) begin
                        r_cnt <= '0;
                        if (w_rxs) begin
                            // New byte wins over a same-cycle ack; overrun only if unacked.
                            r_rx_data  <= r_shift;
                            r_rx_valid <= 1'b1;
                            r_overrun  <= r_rx_valid & ~rx_ack;
                            r_state    <= c_ST_IDLE;
                            r_busy     <= 1'b0;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= c_ST_BREAK;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                c_ST_BREAK: begin
                    r_cnt <= '0;
                    if (w_rxs) begin
                        r_state <= c_ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign busy      = r_busy;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_deserialize_shifter.sv
`default_nettype none
// ============================================================================
// Module   : tb_deserialize_shifter
// Brief    : Directed and randomized frame checks for deserialize_shifter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_deserialize_shifter;

    localparam int c_CLK_PERIOD = 10;
    localparam int c_BIT_CYC    = 16;
    localparam int c_LATENCY    = 155;
    localparam int c_FRAME_CYC  = 10 * c_BIT_CYC;
    localparam int c_LOG_N      = 16384;

    logic       clk;
    logic       rst;
    logic       serin;
    logic       rx_ack;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       frame_err;
    logic       overrun;

    int vectors;
    int miscompares;
    int cyc;

    logic       log_valid [0:c_LOG_N-1];
    logic       log_busy  [0:c_LOG_N-1];
    logic       log_ferr  [0:c_LOG_N-1];
    logic       log_ovr   [0:c_LOG_N-1];
    logic [7:0] log_data  [0:c_LOG_N-1];

    int         s;
    int         h;
    int         g;
    bit         found;
    bit         pending;
    bit         do_ack;
    int         gap;
    logic [7:0] b;

    deserialize_shifter #(
        .SRC_CLOCK (16),
        .BAUDS     (1)
    ) dut (
        .ser_ck    (clk),
        .rst       (rst),
        .serin     (serin),
        .rx_ack    (rx_ack),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .busy      (busy),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #(c_CLK_PERIOD / 2) clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Per-cycle record of DUT outputs, indexed by the number of rising edges seen.
    always @(negedge clk) begin
        if (cyc < c_LOG_N) begin
            log_valid[cyc] = rx_valid;
            log_busy[cyc]  = busy;
            log_ferr[cyc]  = frame_err;
            log_ovr[cyc]   = overrun;
            log_data[cyc]  = rx_data;
        end
    end

    initial begin
        #(c_CLK_PERIOD * 30000);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int count_high(input int sel, input int first, input int last);
        int n;
        n = 0;
        for (int i = first; i < last; i++) begin
            if (i >= 0 && i < c_LOG_N) begin
                case (sel)
                    0: n += (log_valid[i] === 1'b1) ? 1 : 0;
                    1: n += (log_ferr[i]  === 1'b1) ? 1 : 0;
                    default: n += (log_ovr[i] === 1'b1) ? 1 : 0;
                endcase
            end
        end
        return n;
    endfunction

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Start bit, 8 data bits LSB first, stop bit; each bit held 16 cycles.
    task automatic send_frame(input logic [7:0] d, input logic stop);
        logic [9:0] bits;
        bits = {stop, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            serin = bits[i];
            step(c_BIT_CYC);
        end
    endtask

    task automatic pulse_ack();
        rx_ack = 1'b1;
        step(1);
        rx_ack = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        serin       = 1'b1;
        rx_ack      = 1'b0;
        step(3);
        check("reset_rx_data",   32'(rx_data),   32'h0);
        check("reset_rx_valid",  32'(rx_valid),  32'h0);
        check("reset_busy",      32'(busy),      32'h0);
        check("reset_frame_err", 32'(frame_err), 32'h0);
        check("reset_overrun",   32'(overrun),   32'h0);
        rst = 1'b0;
        step(5);

        // Single frame latency
        s = cyc;
        send_frame(8'hA5, 1'b1);
        check("a5_valid_early", 32'(log_valid[s+c_LATENCY-1]), 32'h0);
        check("a5_valid",       32'(log_valid[s+c_LATENCY]),   32'h1);
        check("a5_data",        32'(log_data[s+c_LATENCY]),    32'hA5);
        check("a5_busy_before", 32'(log_busy[s+c_LATENCY-1]),  32'h1);
        check("a5_busy_done",   32'(log_busy[s+c_LATENCY]),    32'h0);
        pulse_ack();
        check("a5_ack_clears",  32'(rx_valid), 32'h0);
        step(4);

        // Back-to-back frames with an ack after each byte
        s = cyc;
        fork
            begin
                send_frame(8'h3C, 1'b1);
                send_frame(8'hC3, 1'b1);
            end
            begin
                for (int k = 0; k < 2; k++) begin
                    found = 1'b0;
                    for (int i = 0; i < 400; i++) begin
                        step(1);
                        if (rx_valid) begin
                            found = 1'b1;
                            break;
                        end
                    end
                    check("b2b_valid_seen", 32'(found), 32'h1);
                    if (found) pulse_ack();
                end
            end
        join
        check("b2b_data0",     32'(log_data[s+c_LATENCY]),                32'h3C);
        check("b2b_valid0",    32'(log_valid[s+c_LATENCY]),               32'h1);
        check("b2b_data1",     32'(log_data[s+c_FRAME_CYC+c_LATENCY]),    32'hC3);
        check("b2b_valid1_pre",32'(log_valid[s+c_FRAME_CYC+c_LATENCY-1]), 32'h0);
        check("b2b_valid1",    32'(log_valid[s+c_FRAME_CYC+c_LATENCY]),   32'h1);
        check("b2b_no_overrun",32'(count_high(2, s, s + 2*c_FRAME_CYC)),  32'h0);
        step(4);

        // Overrun: second byte with first still pending
        send_frame(8'h11, 1'b1);
        s = cyc;
        send_frame(8'h22, 1'b1);
        check("ovr_pulse_count", 32'(count_high(2, s, s + c_FRAME_CYC)), 32'h1);
        check("ovr_pulse_time",  32'(log_ovr[s+c_LATENCY]),   32'h1);
        check("ovr_data",        32'(log_data[s+c_LATENCY]),  32'h22);
        check("ovr_valid_held",  32'(log_valid[s+c_LATENCY-1]), 32'h1);
        check("ovr_valid",       32'(log_valid[s+c_LATENCY]), 32'h1);

        // Ack coinciding with completion: new byte kept, no overrun
        s = cyc;
        fork
            send_frame(8'h33, 1'b1);
            begin
                step(c_LATENCY - 1);
                rx_ack = 1'b1;
                step(1);
                rx_ack = 1'b0;
            end
        join
        check("ackcoin_no_overrun", 32'(count_high(2, s, s + c_FRAME_CYC)), 32'h0);
        check("ackcoin_data",       32'(log_data[s+c_LATENCY]),   32'h33);
        check("ackcoin_valid",      32'(log_valid[s+c_LATENCY+2]), 32'h1);
        pulse_ack();
        step(4);

        // Framing error followed by a held-low break
        s = cyc;
        send_frame(8'h55, 1'b0);
        step(40 * c_BIT_CYC);
        h = cyc;
        serin = 1'b1;
        step(30);
        check("ferr_count",      32'(count_high(1, s, h + 30)), 32'h1);
        check("ferr_time",       32'(log_ferr[s+c_LATENCY]),   32'h1);
        check("ferr_no_valid",   32'(count_high(0, s, h + 30)), 32'h0);
        check("ferr_busy_break", 32'(log_busy[h+2]), 32'h1);
        check("ferr_busy_freed", 32'(log_busy[h+4]), 32'h0);
        s = cyc;
        send_frame(8'h81, 1'b1);
        check("after_ferr_valid", 32'(log_valid[s+c_LATENCY]), 32'h1);
        check("after_ferr_data",  32'(log_data[s+c_LATENCY]),  32'h81);
        pulse_ack();
        step(4);

        // Short low glitch on an idle line
        g = cyc;
        serin = 1'b0;
        step(3);
        serin = 1'b1;
        step(200);
        check("glitch_busy_rise", 32'(log_busy[g+3]),  32'h1);
        check("glitch_busy_hold", 32'(log_busy[g+10]), 32'h1);
        check("glitch_busy_fall", 32'(log_busy[g+11]), 32'h0);
        check("glitch_no_valid",  32'(count_high(0, g, g + 200)), 32'h0);
        check("glitch_no_ferr",   32'(count_high(1, g, g + 200)), 32'h0);
        check("glitch_no_ovr",    32'(count_high(2, g, g + 200)), 32'h0);

        // Asynchronous reset in the middle of data bit 4
        fork
            send_frame(8'($urandom_range(0, 255)), 1'b1);
            begin
                step(5 * c_BIT_CYC + 8);
                check("mid_busy_before_rst", 32'(busy), 32'h1);
                #2;
                rst = 1'b1;
                #1;
                check("rst_async_data",  32'(rx_data),  32'h0);
                check("rst_async_valid", 32'(rx_valid), 32'h0);
                check("rst_async_busy",  32'(busy),     32'h0);
            end
        join
        step(1);
        rst = 1'b0;
        step(20);
        s = cyc;
        send_frame(8'hF0, 1'b1);
        check("post_rst_valid", 32'(log_valid[s+c_LATENCY]), 32'h1);
        check("post_rst_data",  32'(log_data[s+c_LATENCY]),  32'hF0);
        check("post_rst_pulses", 32'(count_high(1, s, s + c_FRAME_CYC) + count_high(2, s, s + c_FRAME_CYC)), 32'h0);
        pulse_ack();
        step(3);

        // Random bytes, random gaps, random acks; model tracks the pending byte
        pending = 1'b0;
        for (int f = 0; f < 12; f++) begin
            b      = 8'($urandom_range(0, 255));
            do_ack = ($urandom_range(0, 2) != 0);
            gap    = $urandom_range(0, 20);
            s      = cyc;
            send_frame(b, 1'b1);
            check("rnd_data",         32'(log_data[s+c_LATENCY]),    32'(b));
            check("rnd_valid",        32'(log_valid[s+c_LATENCY]),   32'h1);
            check("rnd_valid_before", 32'(log_valid[s+c_LATENCY-1]), 32'(pending));
            check("rnd_overrun",      32'(count_high(2, s, s + c_FRAME_CYC)), 32'(pending));
            pending = 1'b1;
            if (do_ack) begin
                pulse_ack();
                pending = 1'b0;
            end
            step(gap);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
